// File: rtl/pong_pkg.sv
// Shared widths, default VGA 640x480@60 timing, playfield geometry, colours
// and the clipped distance test used by the Pong renderer.
package pong_pkg;

    localparam int COORD_W  = 10;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int BALL_RADIUS   = 4;
    localparam int PADDLE_HALF_W = 4;
    localparam int PADDLE_HALF_H = 32;
    localparam int P1_COL        = 50;
    localparam int P2_COL        = 590;
    localparam int MID_COL       = 320;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [2:0]         rgb_t;

    localparam rgb_t C_BALL   = 3'b111;
    localparam rgb_t C_PADDLE = 3'b011;
    localparam rgb_t C_MID    = 3'b100;
    localparam rgb_t C_BG     = 3'b000;

    typedef struct packed {
        coord_t ball_x;
        coord_t ball_y;
        coord_t paddle1_y;
        coord_t paddle2_y;
    } pos_t;

    localparam pos_t POS_RST = '{ball_x: 10'd320, ball_y: 10'd240,
                                 paddle1_y: 10'd240, paddle2_y: 10'd240};

    // Signed distance one bit wider than a coordinate, so objects near an
    // edge clip instead of wrapping around the counter range.
    function automatic logic near(input coord_t p, input coord_t c, input int r);
        logic signed [COORD_W:0] d;
        logic signed [COORD_W:0] lim;
        d   = $signed({1'b0, p}) - $signed({1'b0, c});
        lim = (COORD_W+1)'(r);
        return (d >= -lim) && (d <= lim);
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Free-running pixel/line counters with raw (unregistered) sync, display
// enable and the once-per-frame commit strobe at the first vblank pixel.
module vga_timing
    import pong_pkg::*;
#(
    parameter int H_ACTIVE = pong_pkg::H_ACTIVE,
    parameter int H_FP     = pong_pkg::H_FP,
    parameter int H_SYNC   = pong_pkg::H_SYNC,
    parameter int H_BP     = pong_pkg::H_BP,
    parameter int V_ACTIVE = pong_pkg::V_ACTIVE,
    parameter int V_FP     = pong_pkg::V_FP,
    parameter int V_SYNC   = pong_pkg::V_SYNC,
    parameter int V_BP     = pong_pkg::V_BP
) (
    input  logic   clk,
    input  logic   rst,
    output coord_t h_cnt,
    output coord_t v_cnt,
    output logic   de_raw,
    output logic   hs_raw,
    output logic   vs_raw,
    output logic   commit
);

    localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == coord_t'(HT - 1)) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == coord_t'(VT - 1)) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    assign de_raw = (h_cnt < coord_t'(H_ACTIVE)) && (v_cnt < coord_t'(V_ACTIVE));
    assign hs_raw = !((h_cnt >= coord_t'(H_ACTIVE + H_FP)) &&
                      (h_cnt <  coord_t'(H_ACTIVE + H_FP + H_SYNC)));
    assign vs_raw = !((v_cnt >= coord_t'(V_ACTIVE + V_FP)) &&
                      (v_cnt <  coord_t'(V_ACTIVE + V_FP + V_SYNC)));
    assign commit = (h_cnt == '0) && (v_cnt == coord_t'(V_ACTIVE));

endmodule

// File: rtl/pong_renderer.sv
// Pong video back end: shadow/active position buffer committed once per
// frame, object hit tests and a single registered output stage.
module pong_renderer
    import pong_pkg::*;
#(
    parameter int H_ACTIVE      = pong_pkg::H_ACTIVE,
    parameter int H_FP          = pong_pkg::H_FP,
    parameter int H_SYNC        = pong_pkg::H_SYNC,
    parameter int H_BP          = pong_pkg::H_BP,
    parameter int V_ACTIVE      = pong_pkg::V_ACTIVE,
    parameter int V_FP          = pong_pkg::V_FP,
    parameter int V_SYNC        = pong_pkg::V_SYNC,
    parameter int V_BP          = pong_pkg::V_BP,
    parameter int BALL_RADIUS   = pong_pkg::BALL_RADIUS,
    parameter int PADDLE_HALF_W = pong_pkg::PADDLE_HALF_W,
    parameter int PADDLE_HALF_H = pong_pkg::PADDLE_HALF_H,
    parameter int P1_COL        = pong_pkg::P1_COL,
    parameter int P2_COL        = pong_pkg::P2_COL,
    parameter int MID_COL       = pong_pkg::MID_COL
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   pos_valid,
    input  coord_t ball_x,
    input  coord_t ball_y,
    input  coord_t paddle1_y,
    input  coord_t paddle2_y,
    output logic   frame_tick,
    output logic   hsync,
    output logic   vsync,
    output logic   de,
    output rgb_t   rgb
);

    coord_t h_cnt, v_cnt;
    logic   de_raw, hs_raw, vs_raw, commit;

    vga_timing #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk(clk), .rst(rst),
        .h_cnt(h_cnt), .v_cnt(v_cnt),
        .de_raw(de_raw), .hs_raw(hs_raw), .vs_raw(vs_raw),
        .commit(commit)
    );

    pos_t pos_in, shadow, active;
    assign pos_in = {ball_x, ball_y, paddle1_y, paddle2_y};

    // A strobe landing on the commit cycle bypasses the shadow so the
    // freshest position is what the next frame shows.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow <= POS_RST;
            active <= POS_RST;
        end else begin
            if (pos_valid) shadow <= pos_in;
            if (commit)    active <= pos_valid ? pos_in : shadow;
        end
    end

    logic hit_ball, hit_pad, hit_mid;
    rgb_t pix;

    assign hit_ball = near(h_cnt, active.ball_x, BALL_RADIUS) &&
                      near(v_cnt, active.ball_y, BALL_RADIUS);
    assign hit_pad  = (near(h_cnt, coord_t'(P1_COL), PADDLE_HALF_W) &&
                       near(v_cnt, active.paddle1_y, PADDLE_HALF_H)) ||
                      (near(h_cnt, coord_t'(P2_COL), PADDLE_HALF_W) &&
                       near(v_cnt, active.paddle2_y, PADDLE_HALF_H));
    assign hit_mid  = ((h_cnt == coord_t'(MID_COL)) || (h_cnt == coord_t'(MID_COL + 1))) &&
                      !v_cnt[3];

    always_comb begin
        pix = C_BG;
        if (de_raw) begin
            if (hit_ball)     pix = C_BALL;
            else if (hit_pad) pix = C_PADDLE;
            else if (hit_mid) pix = C_MID;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hsync      <= 1'b1;
            vsync      <= 1'b1;
            de         <= 1'b0;
            rgb        <= C_BG;
            frame_tick <= 1'b0;
        end else begin
            hsync      <= hs_raw;
            vsync      <= vs_raw;
            de         <= de_raw;
            rgb        <= pix;
            frame_tick <= commit;
        end
    end

endmodule

// File: tb/tb_pong_renderer.sv
// Directed bench for pong_renderer on a shrunken raster (80x55 total,
// 64x48 visible) so whole frames are cheap; geometry values are hand-derived.
module tb_pong_renderer;
    import pong_pkg::*;

    localparam int HA = 64, HF = 4, HS = 8, HB = 4, HT = HA + HF + HS + HB;
    localparam int VA = 48, VF = 2, VS = 2, VB = 3, VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int BR = 4, PHW = 4, PHH = 6, P1 = 10, P2 = 54, MID = 32;

    logic   clk = 1'b0, rst = 1'b1, pos_valid = 1'b0;
    coord_t bx = '0, by = '0, p1y = '0, p2y = '0;
    logic   frame_tick, hsync, vsync, de;
    rgb_t   rgb;

    int n = 0, checks = 0, errors = 0;
    int c7, c7_in, c3, c3_in, c4, blank_bad, tim_bad, vs_low, ft_cnt, ft_pos;

    always #5 clk = ~clk;

    pong_renderer #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .BALL_RADIUS(BR), .PADDLE_HALF_W(PHW), .PADDLE_HALF_H(PHH),
        .P1_COL(P1), .P2_COL(P2), .MID_COL(MID)
    ) dut (
        .clk(clk), .rst(rst), .pos_valid(pos_valid),
        .ball_x(bx), .ball_y(by), .paddle1_y(p1y), .paddle2_y(p2y),
        .frame_tick(frame_tick), .hsync(hsync), .vsync(vsync), .de(de), .rgb(rgb)
    );

    // After tick number n the outputs describe raster pixel n-1.
    task automatic tick();
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input int x, input int y, input int a, input int b);
        bx = coord_t'(x); by = coord_t'(y); p1y = coord_t'(a); p2y = coord_t'(b);
    endtask

    task automatic goto_pixel(input int p);
        while (((n - 1) % FRAME + FRAME) % FRAME != p) tick();
    endtask

    task automatic measure_hsync(input string tag);
        int k, w, fall_n;
        k = 0;
        while (hsync !== 1'b0 && k < 2 * HT) begin tick(); k++; end
        chk({tag, ".first_fall"}, n, HA + HF + 1);
        fall_n = n;
        w = 0;
        while (hsync === 1'b0 && w < 2 * HT) begin tick(); w++; end
        chk({tag, ".low_width"}, w, HS);
        k = 0;
        while (hsync !== 1'b0 && k < 2 * HT) begin tick(); k++; end
        chk({tag, ".line_period"}, n - fall_n, HT);
    endtask

    // Scan one whole frame starting at pixel 0, optionally strobing a new
    // position after the sample of pixel inj.
    task automatic scan(input int bx0, input int bx1, input int by0, input int by1,
                        input int qx0, input int qx1, input int qy0, input int qy1,
                        input int inj, input int ix, input int iy, input int ia, input int ib);
        c7 = 0; c7_in = 0; c3 = 0; c3_in = 0; c4 = 0;
        blank_bad = 0; tim_bad = 0; vs_low = 0; ft_cnt = 0; ft_pos = -1;
        for (int i = 0; i < FRAME; i++) begin
            int h, v;
            logic e_de, e_hs, e_vs;
            h = i % HT;
            v = i / HT;
            e_de = (h < HA) && (v < VA);
            e_hs = !((h >= HA + HF) && (h < HA + HF + HS));
            e_vs = !((v >= VA + VF) && (v < VA + VF + VS));
            if (de !== e_de || hsync !== e_hs || vsync !== e_vs) tim_bad++;
            if (vsync === 1'b0) vs_low++;
            if (frame_tick === 1'b1) begin ft_cnt++; ft_pos = i; end
            if (de !== 1'b1 && rgb !== 3'd0) blank_bad++;
            if (rgb === 3'd7) begin
                c7++;
                if (h >= bx0 && h <= bx1 && v >= by0 && v <= by1) c7_in++;
            end
            if (rgb === 3'd3) begin
                c3++;
                if (h >= qx0 && h <= qx1 && v >= qy0 && v <= qy1) c3_in++;
            end
            if (rgb === 3'd4) c4++;
            if (i == inj) begin drive(ix, iy, ia, ib); pos_valid = 1'b1; end
            tick();
            pos_valid = 1'b0;
        end
    endtask

    task automatic check_frame(input string tag, input int e7, input int e7in,
                               input int e3, input int e3in, input int e4);
        chk({tag, ".timing_bad"}, tim_bad, 0);
        chk({tag, ".vsync_low"}, vs_low, VS * HT);
        chk({tag, ".tick_count"}, ft_cnt, 1);
        chk({tag, ".tick_pos"}, ft_pos, VA * HT);
        chk({tag, ".rgb_in_blank"}, blank_bad, 0);
        chk({tag, ".ball_px"}, c7, e7);
        chk({tag, ".ball_in_box"}, c7_in, e7in);
        chk({tag, ".paddle_px"}, c3, e3);
        chk({tag, ".paddle1_in_box"}, c3_in, e3in);
        chk({tag, ".mid_px"}, c4, e4);
    endtask

    initial begin
        #2 rst = 1'b0;
        #1;
        chk("rst.hsync", int'(hsync), 1);
        chk("rst.vsync", int'(vsync), 1);
        chk("rst.de", int'(de), 0);
        chk("rst.rgb", int'(rgb), 0);
        chk("rst.tick", int'(frame_tick), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        n = 0;

        measure_hsync("boot");
        goto_pixel(0);

        // Reset positions sit off this small raster: only the centre line shows.
        scan(16, 24, 16, 24, 6, 14, 14, 26, 200, 20, 20, 20, 40);
        check_frame("f1_default", 0, 0, 0, 0, 48);

        // Ball (20,20); update mid-frame at line 20 must not show until next frame.
        scan(16, 24, 16, 24, 6, 14, 14, 26, 20 * HT + 5, 33, 30, 20, 40);
        check_frame("f2_ball20", 81, 81, 234, 117, 48);

        // Ball over the centre line hides 3 dashed rows; strobe on the commit cycle.
        scan(29, 37, 26, 34, 6, 14, 14, 26, VA * HT - 1, 10, 10, 40, 40);
        check_frame("f3_ball33", 81, 81, 234, 117, 42);

        scan(6, 14, 6, 14, 6, 14, 34, 46, 100, 2, 2, 40, 40);
        check_frame("f4_commit_bypass", 81, 81, 234, 117, 48);

        scan(0, 6, 0, 6, 6, 14, 34, 46, 100, 62, 47, 40, 40);
        check_frame("f5_corner_clip", 49, 49, 234, 117, 48);

        // Ball partly off the bottom-right, also covering 4 paddle-2 pixels.
        scan(58, 66, 43, 51, 6, 14, 34, 46, -1, 0, 0, 0, 0);
        check_frame("f6_offscreen", 30, 30, 230, 117, 48);

        goto_pixel(20 * HT + MID);
        chk("mid.de_before", int'(de), 1);
        chk("mid.rgb_before", int'(rgb), 4);
        #2 rst = 1'b0;
        #1;
        chk("mid.de_async", int'(de), 0);
        chk("mid.rgb_async", int'(rgb), 0);
        chk("mid.hsync_async", int'(hsync), 1);
        chk("mid.vsync_async", int'(vsync), 1);
        repeat (3) @(posedge clk);
        #1;
        chk("mid.de_held", int'(de), 0);
        @(negedge clk);
        rst = 1'b1;
        n = 0;

        measure_hsync("rerun");
        goto_pixel(0);
        scan(0, 0, 0, 0, 0, 0, 0, 0, -1, 0, 0, 0, 0);
        check_frame("f_after_reset", 0, 0, 0, 0, 48);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pong_renderer.md
Name: pong_renderer

Overview:
Video-side consumer of the Pong game state. Generates 640x480@60 VGA timing from a 25 MHz pixel clock. Latches ball and paddle positions through a shadow/active double buffer that commits once per frame, so no object tears mid-frame. Rasterises ball, paddles and a dashed centre line into 3-bit RGB, and returns a one-cycle frame_tick to the game logic as its per-frame update strobe.

Parameters:
COORD_W, 10, width of all x/y coordinates and counters
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch
H_SYNC, 96, hsync pulse width
H_BP, 48, horizontal back porch (line total 800)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch
V_SYNC, 2, vsync pulse width
V_BP, 33, vertical back porch (frame total 525)
BALL_RADIUS, 4, ball half-size (square ball, 9x9 px)
PADDLE_HALF_W, 4, paddle half-width
PADDLE_HALF_H, 32, paddle half-height
P1_COL, 50, paddle 1 centre x
P2_COL, 590, paddle 2 centre x
MID_COL, 320, left column of the 2-px centre line

Ports:
clk  in  1  pixel clock, 25 MHz
rst  in  1  asynchronous, active-low reset
pos_valid  in  1  strobe: ball_x/ball_y/paddle1_y/paddle2_y are valid this cycle
ball_x  in  COORD_W  ball centre x
ball_y  in  COORD_W  ball centre y
paddle1_y  in  COORD_W  paddle 1 centre y
paddle2_y  in  COORD_W  paddle 2 centre y
frame_tick  out  1  one-cycle pulse at the start of vertical blanking
hsync  out  1  horizontal sync, active-low
vsync  out  1  vertical sync, active-low
de  out  1  display enable (active region)
rgb  out  3  pixel colour {r,g,b}

Behaviour:
- Reset (rst=0, asynchronous): h_cnt=0, v_cnt=0. Outputs: hsync=1, vsync=1, de=0, rgb=0, frame_tick=0. Shadow and active registers: ball=(320,240), paddles=240. Reset mid-frame restarts at (0,0) on the first clock after release.
- Counters:
  - h_cnt runs 0..799 and wraps to 0.
  - v_cnt increments when h_cnt wraps, runs 0..524, then wraps to 0.
- Raw timing, combinational from the counters:
  - de_raw = h_cnt<640 && v_cnt<480.
  - hs_raw low for h_cnt in 656..751.
  - vs_raw low for v_cnt in 490..491.
- Latency: all outputs are registered. The output at cycle t+1 reflects the counters at cycle t. hsync, vsync, de and rgb stay mutually aligned.
- Shadow capture: on pos_valid=1, all four inputs are copied into the shadow registers. The last strobe before commit wins.
- Commit: at h_cnt=0 and v_cnt=480 (first vblank pixel), shadow is copied to active.
  - If pos_valid=1 in the commit cycle, the input values go directly to active (and to shadow).
- frame_tick is registered high for exactly one cycle, following the commit cycle. The game logic may present new positions any time before the next commit.
- Pixel classification uses active registers only, with priority ball > paddle > centre line > background.
  - ball: |h-ball_x|<=BALL_RADIUS && |v-ball_y|<=BALL_RADIUS -> 3'b111
  - paddle n: |h-Pn_COL|<=PADDLE_HALF_W && |v-paddlen_y|<=PADDLE_HALF_H -> 3'b011
  - centre line: h in {MID_COL, MID_COL+1} && v_cnt[3]==0 -> 3'b100
  - background: 3'b000
  - Outside de_raw, rgb=0 regardless of object hits.
- Arithmetic: distances are computed at COORD_W+1 bits, signed. An object near an edge is clipped, never wrapped; e.g. a ball at x=2 must not light x=798 or anything beyond 639. Coordinates above 639/479 are legal and produce only their visible portion, if any.

Decomposition:
- pong_pkg holds:
  - timing constants (H_*/V_* and their totals)
  - COORD_W
  - typedef coord_t (logic [COORD_W-1:0])
  - typedef rgb_t (logic [2:0]) and colour constants C_BALL, C_PADDLE, C_MID, C_BG
- Sub-module vga_timing:
  - contains the h/v counters and raw de/hsync/vsync generation
  - outputs h_cnt, v_cnt, de_raw, hs_raw, vs_raw and a commit strobe
- pong_renderer holds the double buffer, hit tests and output register stage.

Test Plan:
- Release reset, run 2 frames -> hsync falls 656 clocks after the first counted edge and stays low 96 clocks; line period 800; vsync low for exactly 1600 clocks; frame period 420000; frame_tick once per frame, 1 cycle wide.
- pos_valid ball=(100,200), paddles=(100,300), then wait one full frame -> rgb=111 on exactly 81 pixels (x 96..104, y 196..204); paddle 1 gives 9x65=585 pixels of 011 at x 46..54, y 68..132.
- pos_valid ball=(400,300) at v_cnt=100 -> the remainder of the current frame still draws the old ball; the next frame draws the ball at (400,300).
- pos_valid coinciding with the commit cycle (h=0, v=480), ball=(10,10) -> the very next frame draws at (10,10), not the previous shadow value.
- ball=(2,2) -> exactly 49 lit pixels (x 0..6, y 0..6); zero ball pixels at x>=796 or y>=476; rgb=0 whenever de=0.
- Assert rst low mid-line (h=300, v=200) for 3 cycles without a clock edge -> outputs go to reset values immediately; after release the first hsync fall is again 656 clocks later.
